vga_bar_render: RTL



---
 rtl/vga_bar_render.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_bar_render.sv
// vga_bar_render: pixel-colour stage behind the 640x480 VGA sync generator.
// Renders the latest XADC sample as a vertical bar with green/yellow/red
// threshold colouring. The output is a two-stage pipeline that advances on
// the rising edge of the 25 MHz p_tick. Syncs are delayed by the same amount
// so they stay aligned with rgb.
// Build option: define VGA_BAR_PEAK_HOLD_EN to add a white peak-marker line
// that decays by one row every DECAY_FRAMES frames.
module vga_bar_render #(
    parameter int unsigned BAR_X0       = 300,
    parameter int unsigned BAR_W        = 40,
    parameter int unsigned LVL_WARN     = 320,
    parameter int unsigned LVL_CRIT     = 420,
    parameter logic [11:0] BG_COLOR     = 12'h112,
    parameter int unsigned DECAY_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        hsync_n_i,
    input  logic        vsync_n_i,
    input  logic [11:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [11:0] rgb,
    output logic        hsync_n_o,
    output logic        vsync_n_o
);

    localparam logic [9:0]  X_LO       = 10'(BAR_X0);
    localparam logic [9:0]  X_HI       = 10'(BAR_X0 + BAR_W);
    localparam logic [9:0]  LVL_WARN_V = 10'(LVL_WARN);
    localparam logic [9:0]  LVL_CRIT_V = 10'(LVL_CRIT);
    localparam logic [11:0] COL_RED    = 12'hF00;
    localparam logic [11:0] COL_YEL    = 12'hFF0;
    localparam logic [11:0] COL_GRN    = 12'h0F0;

    // Scale a 12-bit sample to a bar height of 0..479 rows.
    function automatic logic [9:0] bar_height(input logic [11:0] lvl);
        return 10'((20'(lvl) * 20'd15) >> 7);
    endfunction

    logic        p_tick_q;
    logic        tick_en;
    logic        frame_upd;
    logic        accept;
    logic        full;
    logic [11:0] shadow;
    logic [11:0] active;
    logic [9:0]  h_act;
    logic        in_col;
    logic [9:0]  row_lvl;

    logic        s1_in_bar;
    logic [9:0]  s1_row_lvl;
    logic        s1_video_on;
    logic        s1_hsync_n;
    logic        s1_vsync_n;
    logic [11:0] rgb_next;

    // Edge-detect the pixel square wave so everything stays on clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_tick_q <= 1'b0;
        end else begin
            p_tick_q <= p_tick;
        end
    end

    assign tick_en = p_tick & ~p_tick_q;

    // s1_vsync_n holds vsync as seen on the previous tick, so a 1->0 step marks a new frame.
    assign frame_upd    = tick_en & s1_vsync_n & ~vsync_n_i;
    assign accept       = sample_valid & ~full;
    assign sample_ready = ~full;

    // Shadow register and its full flag; a pending sample is only consumed at a frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            full   <= 1'b0;
        end else begin
            if (accept) begin
                shadow <= sample_data;
            end
            if (frame_upd && full) begin
                full <= 1'b0;
            end else if (accept) begin
                full <= 1'b1;
            end
        end
    end

    // Displayed level changes only at the vsync falling edge so a frame is never torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
        end else if (frame_upd && full) begin
            active <= shadow;
        end
    end

    assign h_act   = bar_height(active);
    assign in_col  = (pixel_x >= X_LO) && (pixel_x < X_HI);
    assign row_lvl = 10'd479 - pixel_y;

`ifdef VGA_BAR_PEAK_HOLD_EN
    localparam int unsigned DCNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_RELOAD = DCNT_W'(DECAY_FRAMES - 1);

    logic [9:0]        peak;
    logic [DCNT_W-1:0] decay_cnt;
    logic [9:0]        h_next;
    logic              peak_line;
    logic              s1_peak_line;

    // Height that becomes visible at this frame boundary.
    assign h_next = full ? bar_height(shadow) : h_act;

    // Peak tracker: a new maximum reloads the decay down-counter; at terminal count the peak drops one row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak      <= '0;
            decay_cnt <= '0;
        end else if (frame_upd) begin
            if (h_next > peak) begin
                peak      <= h_next;
                decay_cnt <= DCNT_RELOAD;
            end else if (decay_cnt == '0) begin
                if (peak != '0) begin
                    peak <= peak - 10'd1;
                end
                decay_cnt <= DCNT_RELOAD;
            end else begin
                decay_cnt <= decay_cnt - 1'b1;
            end
        end
    end

    assign peak_line = in_col && (peak != '0) &&
                       ((row_lvl == peak) || (row_lvl == peak - 10'd1));

    // Peak-line flag travels alongside the other stage-1 terms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_peak_line <= 1'b0;
        end else if (tick_en) begin
            s1_peak_line <= peak_line;
        end
    end
`endif

    // Stage 1: geometry decisions and sync capture for the current pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_in_bar   <= 1'b0;
            s1_row_lvl  <= '0;
            s1_video_on <= 1'b0;
            s1_hsync_n  <= 1'b1;
            s1_vsync_n  <= 1'b1;
        end else if (tick_en) begin
            s1_in_bar   <= video_on && in_col && (pixel_y >= (10'd480 - h_act));
            s1_row_lvl  <= row_lvl;
            s1_video_on <= video_on;
            s1_hsync_n  <= hsync_n_i;
            s1_vsync_n  <= vsync_n_i;
        end
    end

    // Colour priority: blanking, then peak marker, then threshold bands, then background.
    always_comb begin
        rgb_next = BG_COLOR;
        if (!s1_video_on) begin
            rgb_next = '0;
        end
`ifdef VGA_BAR_PEAK_HOLD_EN
        else if (s1_peak_line) begin
            rgb_next = 12'hFFF;
        end
`endif
        else if (s1_in_bar && (s1_row_lvl >= LVL_CRIT_V)) begin
            rgb_next = COL_RED;
        end else if (s1_in_bar && (s1_row_lvl >= LVL_WARN_V)) begin
            rgb_next = COL_YEL;
        end else if (s1_in_bar) begin
            rgb_next = COL_GRN;
        end
    end

    // Stage 2: registered colour and matching sync outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb       <= '0;
            hsync_n_o <= 1'b1;
            vsync_n_o <= 1'b1;
        end else if (tick_en) begin
            rgb       <= rgb_next;
            hsync_n_o <= s1_hsync_n;
            vsync_n_o <= s1_vsync_n;
        end
    end

endmodule
